// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit layout, FSM state type and a STATUS packer.
package riscv_mmio_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Builds the STATUS read word; unused bits stay zero.
  function automatic logic [31:0] uart_status_word(
    input logic       busy,
    input logic       full,
    input logic       empty,
    input logic       ovf,
    input logic [3:0] count
  );
    logic [31:0] w;
    w = '0;
    w[STATUS_BUSY_BIT]            = busy;
    w[STATUS_FULL_BIT]            = full;
    w[STATUS_EMPTY_BIT]           = empty;
    w[STATUS_OVF_BIT]             = ovf;
    w[STATUS_COUNT_LSB +: 4]      = count;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head (dout) and occupancy count.
// Push is refused when full and pop when empty; both may occur on one edge.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next-state for storage, pointers (wrap naturally at DEPTH) and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Stores to TXDATA queue bytes; the FSM below drains the queue onto tx.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | tx high; pops the FIFO head as soon as one is available
//   START | tx low for one bit time
//   DATA  | tx = shift[0] for one bit time per bit, LSB first, 8 bits
//   STOP  | tx high for one bit time, then back to IDLE
//
// tx is registered from the next state, so it changes together with the state.
module mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int                 FCNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bidx_q, bidx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;

  logic [3:0]        offset;
  logic              txdata_hit, status_hit;
  logic              push, pop, ovf_set, ovf_clr;
  logic [7:0]        fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic              busy;
  logic              unused_bits;

  // Word-granular decode: the low two address bits are don't-care.
  assign sel        = (a[31:4] == BASE_ADDR[31:4]);
  assign offset     = {a[3:2], 2'b00};
  assign txdata_hit = sel & (offset == UART_TXDATA);
  assign status_hit = sel & (offset == UART_STATUS);
  assign unused_bits = ^{wd[31:8], a[1:0]};

  // Full is sampled before this edge's pop, so a store while full is always dropped.
  assign push    = we & txdata_hit & ~fifo_full;
  assign ovf_set = we & txdata_hit & fifo_full;
  assign ovf_clr = we & status_hit & wd[STATUS_OVF_BIT];
  assign busy    = (state_q != IDLE);
  assign tx      = tx_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wd[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow flag; a set on the same edge beats a clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  // Combinational read mux; zero whenever the block is not addressed.
  always_comb begin
    rd = '0;
    if (status_hit) begin
      rd = uart_status_word(busy, fifo_full, fifo_empty, ovf_q, 4'(fifo_count));
    end
  end

  // Next-state, baud counter, bit index, shift register and line level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bidx_d  = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bidx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Transmitter and flag registers; reset abandons any frame and idles the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. Stores are fed to a timeline model
// (each accepted byte gets an acceptance edge and a frame start edge); expected
// frames are queued and a line monitor decodes tx and checks them in order.
module tb_mmio_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [31:0] a   = 32'h60;
  logic [31:0] wd  = 32'h0;
  logic [31:0] rd;
  logic        sel;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int epoch  = 0;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         start;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  rec_t recs[$];
  exp_t exp_q[$];
  int   last_start = 0;
  bit   have_last  = 0;
  bit   m_ovf      = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_0100),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int held_before(input int e);
    int n = 0;
    foreach (recs[i]) if (recs[i].acc <= e - 1 && recs[i].start >= e) n++;
    return n;
  endfunction

  function automatic int held_after(input int e);
    int n = 0;
    foreach (recs[i]) if (recs[i].acc <= e && recs[i].start > e) n++;
    return n;
  endfunction

  function automatic bit model_busy(input int e);
    foreach (recs[i]) if (recs[i].start <= e && e <= recs[i].start + FRAME - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_status(input int e);
    logic [31:0] s;
    int c;
    c = held_after(e);
    s = '0;
    s[0]   = model_busy(e);
    s[1]   = (c == DEPTH);
    s[2]   = (c == 0);
    s[3]   = m_ovf;
    s[7:4] = 4'(c);
    return s;
  endfunction

  // Store landing on edge e.
  function automatic void model_store(input int e, input logic [31:0] addr, input logic [31:0] data);
    rec_t r;
    exp_t x;
    if (addr[31:4] != 28'h000_0010) return;
    if (addr[3:2] == 2'd0) begin
      if (held_before(e) < DEPTH) begin
        r.data  = data[7:0];
        r.acc   = e;
        r.start = e + 1;
        if (have_last && last_start + FRAME + 1 > r.start) r.start = last_start + FRAME + 1;
        recs.push_back(r);
        x.data  = r.data;
        x.start = r.start;
        exp_q.push_back(x);
        last_start = r.start;
        have_last  = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (addr[3:2] == 2'd1 && data[3]) begin
      m_ovf = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    recs.delete();
    exp_q.delete();
    have_last = 1'b0;
    m_ovf     = 1'b0;
    epoch++;
  endfunction

  // ---------------- bus tasks ----------------
  task automatic bus_store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1; a = addr; wd = data;
    model_store(cyc + 1, addr, data);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    we = 1'b0; a = 32'h60; wd = 32'h0;
  endtask

  task automatic check_status(input string nm);
    @(negedge clk);
    we = 1'b0; a = 32'h104; wd = 32'h0;
    #1;
    chk(nm, rd, model_status(cyc));
  endtask

  task automatic check_rd(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    we = 1'b0; a = addr; wd = 32'h0;
    #1;
    chk(nm, rd, exp);
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || model_busy(cyc)) && n < budget) begin
      check_status({nm, "_status"});
      n++;
    end
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- line monitor ----------------
  initial begin
    int         s, ep;
    logic [7:0] b;
    logic       sb, pb;
    exp_t       x;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        s  = cyc;
        ep = epoch;
        repeat (CPB / 2) @(negedge clk);
        sb = tx;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        pb = tx;
        if (ep == epoch && !rst) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'(b), 32'hFFFF_FFFF);
          end else begin
            x = exp_q.pop_front();
            chk("frame_start_cycle", 32'(s), 32'(x.start));
            chk("frame_data", 32'(b), 32'(x.data));
            chk("frame_start_stop_bits", {30'd0, sb, pb}, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0, r, n;
    logic [31:0] ad;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check_rd("reset_status", 32'h104, 32'h4);
    chk("reset_tx", 32'(tx), 32'd1);
    check_rd("unsel_rd", 32'h60, 32'h0);
    chk("unsel_sel", 32'(sel), 32'd0);
    check_rd("txdata_reads_zero", 32'h100, 32'h0);
    chk("sel_base", 32'(sel), 32'd1);

    // Single frame 0x55, STATUS tracked every cycle.
    bus_store(32'h100, 32'h55);
    drain("single", 400);

    // Burst of six: five accepted, sixth dropped.
    for (int i = 0; i < 6; i++) bus_store(32'h100, 32'hA1 + i);
    check_rd("burst_status", 32'h104, 32'h4B);
    bus_store(32'h104, 32'h0);
    check_rd("clear_bit3_zero_keeps_ovf", 32'h104, 32'h4B);
    bus_store(32'h104, 32'h8);
    check_rd("ovf_cleared", 32'h104, 32'h43);
    bus_store(32'h100, 32'h77);
    check_rd("ovf_set_again", 32'h104, 32'h4B);
    bus_store(32'h104, 32'hFFFF_FFF8);
    check_rd("ovf_cleared_again", 32'h104, 32'h43);
    drain("burst", 1200);

    // Unselected store.
    bus_store(32'hFF, 32'hFF);
    bus_store(32'h60, 32'hFF);
    #1;
    chk("unsel_store_sel", 32'(sel), 32'd0);
    chk("unsel_store_rd", rd, 32'h0);
    for (int i = 0; i < 20; i++) begin
      bus_idle();
      #1;
      chk("unsel_tx_idle", 32'(tx), 32'd1);
    end
    check_rd("unsel_status", 32'h104, 32'h4);

    // Reset 40 cycles into a frame with two bytes queued.
    bus_store(32'h100, 32'h00);
    bus_store(32'h100, 32'h11);
    bus_store(32'h100, 32'h22);
    bus_idle();
    s0 = exp_q[0].start;
    n  = 0;
    while (cyc < s0 + 40 && n < 100) begin
      bus_idle();
      n++;
    end
    chk("pre_reset_tx_low", 32'(tx), 32'd0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("reset_tx_immediate", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_rd("post_reset_status", 32'h104, 32'h4);
    for (int i = 0; i < 400; i++) check_status("post_reset_quiet");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        ad = 32'h100 | 32'($urandom_range(0, 3));
        bus_store(ad, $urandom());
      end else if (r < 30) begin
        bus_store(32'h104 | 32'($urandom_range(0, 3)), $urandom());
      end else if (r < 33) begin
        bus_store($urandom_range(0, 1) ? 32'h108 : 32'h10C, $urandom());
      end else if (r < 36) begin
        bus_store($urandom_range(0, 1) ? 32'h110 : 32'hF0, $urandom());
      end else if (r < 40) begin
        check_rd("reserved_rd", $urandom_range(0, 1) ? 32'h108 : 32'h100, 32'h0);
      end else begin
        check_status("rand_status");
      end
    end
    drain("final", 1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
